// File: rtl/mem_if_pkg.sv
// mem_if_pkg: constants and types shared by the line-memory initiator and the memory model
package mem_if_pkg;
    localparam int LINE_BYTES       = 16;
    localparam int LINE_WIDTH       = 128;
    localparam int LINE_OFFSET_BITS = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
    typedef enum logic {CLIENT_ICACHE, CLIENT_DCACHE} client_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin icache/dcache initiator for the 128-bit line memory port,
// one transaction in flight, request latched at grant and held until the memory's ready pulse
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_icache_req,
    input  logic [ADDR_WIDTH-1:0] in_icache_addr,
    output logic                  out_icache_ready,
    output logic [LINE_WIDTH-1:0] out_icache_data,
    input  logic                  in_dcache_req,
    input  logic                  in_dcache_write,
    input  logic [ADDR_WIDTH-1:0] in_dcache_addr,
    input  logic [LINE_WIDTH-1:0] in_dcache_write_data,
    output logic                  out_dcache_ready,
    output logic [LINE_WIDTH-1:0] out_dcache_data,
    output logic                  out_mem_read_en,
    output logic                  out_mem_write_en,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [LINE_WIDTH-1:0] out_mem_write_data,
    input  logic [LINE_WIDTH-1:0] in_mem_read_data,
    input  logic                  in_mem_ready
);
    import mem_if_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    arb_state_t            state, state_next;
    client_t               grant, pick;
    logic                  write_flag, any_req;
    logic [ADDR_WIDTH-1:0] addr_q, pick_addr;
    logic [LINE_WIDTH-1:0] wdata_q, idata_q, ddata_q;

    // grant doubles as the last-grant bit for the next tie
    function automatic client_t rr_pick(input logic i_req, input logic d_req, input client_t last);
        return (i_req && d_req) ? (last == CLIENT_ICACHE ? CLIENT_DCACHE : CLIENT_ICACHE)
                                : (d_req ? CLIENT_DCACHE : CLIENT_ICACHE);
    endfunction

    always_comb begin
        any_req          = in_icache_req || in_dcache_req;
        pick             = rr_pick(in_icache_req, in_dcache_req, grant);
        pick_addr        = (pick == CLIENT_DCACHE ? in_dcache_addr : in_icache_addr) & LINE_MASK;
        state_next       = state == IDLE  ? (any_req ? ISSUE : IDLE)
                         : state == ISSUE ? (in_mem_ready ? RESP : ISSUE)
                         : IDLE;
        // enables drop in the ready cycle so the memory never sees a stale request
        out_mem_read_en  = state == ISSUE && !write_flag && !in_mem_ready;
        out_mem_write_en = state == ISSUE && write_flag && !in_mem_ready;
        out_icache_ready = state == RESP && grant == CLIENT_ICACHE;
        out_dcache_ready = state == RESP && grant == CLIENT_DCACHE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= CLIENT_ICACHE;
            write_flag <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            idata_q    <= '0;
            ddata_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                grant      <= pick;
                write_flag <= pick == CLIENT_DCACHE && in_dcache_write;
                addr_q     <= pick_addr;
                wdata_q    <= pick == CLIENT_DCACHE ? in_dcache_write_data : '0;
            end
            if (state == ISSUE && in_mem_ready && !write_flag && grant == CLIENT_ICACHE)
                idata_q <= in_mem_read_data;
            if (state == ISSUE && in_mem_ready && !write_flag && grant == CLIENT_DCACHE)
                ddata_q <= in_mem_read_data;
        end
    end

    assign out_mem_addr       = addr_q;
    assign out_mem_write_data = wdata_q;
    assign out_icache_data    = idata_q;
    assign out_dcache_data    = ddata_q;
endmodule
